// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  // Wide enough for a load value of MEM_LAT-1 with MEM_LAT up to 15.
  localparam int unsigned CntW          = 4;
  localparam int unsigned MemLatDefault = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnD  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signal bundle of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);

  logic              if_req;
  logic              if_kill;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [63:0]       d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_kill, if_addr,
    output if_rdata, if_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory model side.
  modport master (
    output if_req, if_kill, if_addr,
    input  if_rdata, if_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency counter: load on grant, count down while busy, flag zero.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported memory.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MemLatDefault,
  parameter int unsigned ADDR_W  = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e            state_d, state_q;
  owner_e            owner_d, owner_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              we_d, we_q;
  logic [63:0]       wdata_d, wdata_q;
  logic [31:0]       if_rdata_d, if_rdata_q;
  logic [63:0]       d_rdata_d, d_rdata_q;
  logic              if_ready_d, if_ready_q;
  logic              d_ready_d, d_ready_q;

  logic cnt_load, cnt_dec, cnt_zero;
  logic if_cand, grant_if, grant_d;

  // A kill in the same cycle keeps the fetch out of arbitration entirely.
  assign if_cand = bus.if_req && !bus.if_kill;

`ifdef MEM_ARB_RR_EN
  owner_e last_d, last_q;

  always_comb begin
    grant_d  = bus.d_req && (!if_cand || (last_q == OwnIf));
    grant_if = if_cand && !grant_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle) begin
      if (grant_d) begin
        last_d = OwnD;
      end else if (grant_if) begin
        last_d = OwnIf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OwnIf;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    grant_d  = bus.d_req;
    grant_if = if_cand && !bus.d_req;
  end
`endif

  mem_arb_lat_cnt u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CntW'(MEM_LAT - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          owner_d  = OwnD;
          addr_d   = bus.d_addr;
          we_d     = bus.d_we;
          wdata_d  = bus.d_wdata;
          cnt_load = 1'b1;
          state_d  = StBusy;
        end else if (grant_if) begin
          owner_d  = OwnIf;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          cnt_load = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        cnt_dec = 1'b1;
        if ((owner_q == OwnIf) && bus.if_kill) begin
          state_d = StIdle;
        end else if (cnt_zero) begin
          state_d = StDone;
          if (owner_q == OwnIf) begin
            if_rdata_d = addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            if_ready_d = 1'b1;
          end else begin
            // Stores complete normally but leave the load data register alone.
            if (!we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
            d_ready_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  assign bus.mem_en    = (state_q == StBusy);
  assign bus.mem_we    = (state_q == StBusy) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=2; honours MEM_ARB_RR_EN if defined.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  mem_arbiter_if #(.ADDR_W(64)) bus ();

  mem_arbiter #(
    .MEM_LAT (2),
    .ADDR_W  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_kill   = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;

    // Reset state
    #3;
    check("rst_mem_en", 64'(bus.mem_en), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_if_ready", 64'(bus.if_ready), 64'd0);
    check("rst_d_ready", 64'(bus.d_ready), 64'd0);
    check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    check("rst_d_rdata", bus.d_rdata, 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Single fetch, low word
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h8;
    bus.mem_rdata = 64'hAAAA5555_12345678;
    step();
    check("f1_busy1_en", 64'(bus.mem_en), 64'd1);
    check("f1_busy1_addr", bus.mem_addr, 64'h8);
    check("f1_busy1_we", 64'(bus.mem_we), 64'd0);
    bus.if_req = 1'b0;
    step();
    check("f1_busy2_en", 64'(bus.mem_en), 64'd1);
    check("f1_busy2_rdy", 64'(bus.if_ready), 64'd0);
    step();
    check("f1_done_en", 64'(bus.mem_en), 64'd0);
    check("f1_done_rdy", 64'(bus.if_ready), 64'd1);
    check("f1_rdata", 64'(bus.if_rdata), 64'h12345678);
    step();
    check("f1_idle_rdy", 64'(bus.if_ready), 64'd0);
    check("f1_rdata_hold", 64'(bus.if_rdata), 64'h12345678);

    // Simultaneous request after an IF grant: D first in both modes
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h20;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 64'h100;
    bus.mem_rdata = 64'h11112222_33334444;
    step();
    check("sim1_first_addr", bus.mem_addr, 64'h100);
    step();
    step();
    check("sim1_d_ready", 64'(bus.d_ready), 64'd1);
    check("sim1_if_ready", 64'(bus.if_ready), 64'd0);
    check("sim1_d_rdata", bus.d_rdata, 64'h11112222_33334444);
    bus.d_req = 1'b0;
    step();
    check("sim1_idle_en", 64'(bus.mem_en), 64'd0);
    check("sim1_idle_drdy", 64'(bus.d_ready), 64'd0);
    step();
    check("sim1_if_grant_en", 64'(bus.mem_en), 64'd1);
    check("sim1_if_grant_addr", bus.mem_addr, 64'h20);
    bus.if_req = 1'b0;
    step();
    step();
    check("sim1_if_ready", 64'(bus.if_ready), 64'd1);
    check("sim1_if_rdata", 64'(bus.if_rdata), 64'h33334444);
    step();

    // Store
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h40;
    bus.d_wdata = 64'h7;
    step();
    check("st_busy1_en", 64'(bus.mem_en), 64'd1);
    check("st_busy1_we", 64'(bus.mem_we), 64'd1);
    check("st_busy1_addr", bus.mem_addr, 64'h40);
    check("st_busy1_wdata", bus.mem_wdata, 64'h7);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    step();
    check("st_busy2_we", 64'(bus.mem_we), 64'd1);
    step();
    check("st_done_rdy", 64'(bus.d_ready), 64'd1);
    check("st_done_we", 64'(bus.mem_we), 64'd0);
    check("st_d_rdata_kept", bus.d_rdata, 64'h11112222_33334444);
    step();
    check("st_idle_rdy", 64'(bus.d_ready), 64'd0);

    // Simultaneous request after a D grant: RR picks IF, fixed picks D
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h4;
    bus.d_req     = 1'b1;
    bus.d_addr    = 64'h80;
    bus.mem_rdata = 64'hCAFEF00D_DEADBEEF;
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
`ifdef MEM_ARB_RR_EN
    check("sim2_first_addr", bus.mem_addr, 64'h4);
    step();
    step();
    check("sim2_if_ready", 64'(bus.if_ready), 64'd1);
    check("sim2_if_rdata", 64'(bus.if_rdata), 64'hCAFEF00D);
`else
    check("sim2_first_addr", bus.mem_addr, 64'h80);
    step();
    step();
    check("sim2_d_ready", 64'(bus.d_ready), 64'd1);
    check("sim2_d_rdata", bus.d_rdata, 64'hCAFEF00D_DEADBEEF);
`endif
    step();

    // Fetch of the upper word
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'hC;
    bus.mem_rdata = 64'h99998888_77776666;
    step();
    bus.if_req = 1'b0;
    step();
    step();
    check("f2_rdy", 64'(bus.if_ready), 64'd1);
    check("f2_rdata_hi", 64'(bus.if_rdata), 64'h99998888);
    step();

    // Kill in first BUSY cycle, pending data request follows
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h10;
    bus.mem_rdata = 64'h01234567_89ABCDEF;
    step();
    check("k_busy_en", 64'(bus.mem_en), 64'd1);
    bus.if_req  = 1'b0;
    bus.if_kill = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_addr  = 64'h200;
    step();
    check("k_idle_en", 64'(bus.mem_en), 64'd0);
    check("k_idle_rdy", 64'(bus.if_ready), 64'd0);
    bus.if_kill = 1'b0;
    step();
    check("k_d_grant_en", 64'(bus.mem_en), 64'd1);
    check("k_d_grant_addr", bus.mem_addr, 64'h200);
    bus.d_req = 1'b0;
    step();
    step();
    check("k_d_ready", 64'(bus.d_ready), 64'd1);
    check("k_no_if_ready", 64'(bus.if_ready), 64'd0);
    check("k_if_rdata_kept", 64'(bus.if_rdata), 64'h99998888);
    step();

    // Asynchronous reset mid-BUSY
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h30;
    step();
    check("r_busy_en", 64'(bus.mem_en), 64'd1);
    bus.if_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("r_async_en", 64'(bus.mem_en), 64'd0);
    check("r_async_addr", bus.mem_addr, 64'd0);
    check("r_async_rdata", 64'(bus.if_rdata), 64'd0);
    check("r_async_drdata", bus.d_rdata, 64'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("r_no_if_ready", 64'(bus.if_ready), 64'd0);
      check("r_no_en", 64'(bus.mem_en), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory access latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 64: byte-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1 (fetch request), if_kill in 1 (abort fetch), if_addr in ADDR_W (fetch address), if_rdata out 32 (instruction word), if_ready out 1 (fetch complete).
REQ-006 SHALL have ports d_req in 1 (data request), d_we in 1 (1 = store), d_addr in ADDR_W (data address), d_wdata in 64 (store data), d_rdata out 64 (load data), d_ready out 1 (data complete).
REQ-007 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 64, mem_rdata in 64, which together form the single-ported unified memory.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE, plus an owner register (IF or D) and a latency counter 0..MEM_LAT-1.
REQ-009 SHALL, in IDLE, grant d_req over if_req (fixed priority); on grant, latch owner, address, we and wdata, set the counter to MEM_LAT-1, and enter BUSY at the next edge.
REQ-010 SHALL block IF grant in any IDLE cycle in which if_kill=1.
REQ-011 SHALL hold mem_en=1 and drive latched mem_addr, mem_we and mem_wdata for exactly MEM_LAT BUSY cycles, and drive mem_en=0 and mem_we=0 in IDLE and DONE.
REQ-012 SHALL decrement the counter each BUSY cycle; at the edge where counter=0, capture mem_rdata into the owner's rdata register and enter DONE.
REQ-013 SHALL assert the owner's ready (registered) for exactly one cycle, in DONE, then return to IDLE at the next edge; grant-to-ready latency is MEM_LAT+1 edges.
REQ-014 SHALL present if_rdata as the low 32 bits of mem_rdata, or bits [63:32] when the captured if_addr[2]=1.
REQ-015 SHALL hold if_rdata and d_rdata stable until the next completion for the same owner.
REQ-016 SHALL ignore requests sampled in DONE, so a request still high is re-arbitrated in the following IDLE cycle; throughput is one access per MEM_LAT+2 cycles.
REQ-017 SHALL, on if_kill=1 during an IF-owned BUSY, drop mem_en and go to IDLE at the next edge without asserting if_ready.
REQ-018 SHALL ignore if_kill in DONE and during D-owned transactions.
REQ-019 SHALL treat a store identically for timing and assert d_ready, with d_rdata unchanged.

Reset
REQ-020 SHALL, while reset=0, immediately force state IDLE, counter 0, owner IF, last-grant IF, and drive all outputs (mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata) to 0.
REQ-021 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no ready pulse issued after reset deasserts.

Configuration
REQ-022 SHALL, with macro MEM_ARB_RR_EN defined, resolve simultaneous if_req/d_req in IDLE by granting the requester not granted last (round-robin) and update last-grant on every grant.
REQ-023 SHALL, without MEM_ARB_RR_EN, use the fixed data priority of REQ-009 and omit the last-grant register.

Structure
REQ-024 SHALL place the state enum (IDLE/BUSY/DONE), the owner enum (IF/D), the counter width constant, and the default MEM_LAT in shared package mem_arb_pkg.
REQ-025 SHALL implement the load/decrement/zero-detect counter as sub-module mem_arb_lat_cnt.

Verification (MEM_LAT=2)
REQ-026 SHALL verify a single fetch: if_req=1, if_addr=0x8, mem_rdata=0xAAAA5555_12345678 -> mem_en high for 2 cycles, if_ready pulses at the 3rd edge after grant, if_rdata=0x12345678.
REQ-027 SHALL verify a simultaneous request without the macro: if_req=d_req=1 in IDLE -> D is served first, then IF is granted in the IDLE cycle after d_ready; with MEM_ARB_RR_EN and last-grant=D -> IF is served first.
REQ-028 SHALL verify a store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x7 -> mem_we=mem_en=1 for 2 cycles with mem_addr=0x40, d_ready pulses once, d_rdata unchanged.
REQ-029 SHALL verify a kill: if_kill=1 in the 1st BUSY cycle of a fetch -> mem_en=0 next cycle, state IDLE, no if_ready, and a pending d_req is granted the following cycle.
REQ-030 SHALL verify reset mid-BUSY: reset=0 asynchronously in BUSY -> mem_en=0 without waiting for a clock edge, and no ready pulse appears after release.
